canvas_write_scheduler: RTL
===========================

CANVAS_WRITE_SCHEDULER -- requirements
Module: canvas_write_scheduler

Interface
REQ-001: Parameter CANVAS_W, default 160, canvas width in pixels.
REQ-002: Parameter CANVAS_H, default 120, canvas height in pixels.
REQ-003: Parameter BRUSH, default 3, brush edge length in pixels; SHALL be odd and at least 1.
REQ-004: clk  input  1  single system clock; all state changes on its rising edge.
REQ-005: rst_n  input  1  reset, asynchronous and active-low.
REQ-006: paint_req  input  1  level request to stamp the brush; held by requester until paint_ack.
REQ-007: paint_x  input  8  brush centre column; paint_y  input  7  brush centre row.
REQ-008: color  input  3  pen color code from the color selector (000 white/erase ... 111 black).
REQ-009: clear_req  input  1  one-cycle pulse requesting a full-canvas clear.
REQ-010: paint_ack  output  1  one-cycle pulse marking acceptance of a paint request.
REQ-011: clear_done  output  1  one-cycle pulse in the cycle after the last clear write.
REQ-012: busy  output  1  high whenever state is not IDLE.
REQ-013: fb_we  output  1  frame-buffer write enable; fb_x  output  8; fb_y  output  7; fb_color  output  3.

Function
REQ-014: The block SHALL be the sole master of the frame-buffer write port, with one write per cycle maximum.
REQ-015: All outputs SHALL be registered.
REQ-016: The FSM SHALL have exactly three states: IDLE, PAINT, CLEAR.
REQ-017: In IDLE, fb_we SHALL be 0.
REQ-018: Clear pending flag: set by clear_req in any state except CLEAR; cleared when a clear is started.
REQ-019: From IDLE, at a rising edge with the clear pending flag set or clear_req=1, the FSM SHALL enter CLEAR; clear takes priority over paint_req.
REQ-020: From IDLE, at a rising edge with paint_req=1 and no clear pending, the FSM SHALL enter PAINT.
REQ-021: On entering PAINT, the block SHALL latch paint_x, paint_y and color, and SHALL drive paint_ack=1 for exactly the following cycle.
REQ-022: PAINT sequence:
- Visits offsets dx,dy in -(BRUSH/2)..+(BRUSH/2), row-major (dy outer, dx inner).
- One offset per cycle; exactly BRUSH*BRUSH cycles.
- The first offset is presented in the cycle right after the accepting edge.
REQ-023: Offset arithmetic SHALL use at least 1 extra sign bit.
- A pixel with x<0, x>=CANVAS_W, y<0 or y>=CANVAS_H is clipped: fb_we=0 that cycle, and the cycle is still consumed.
- In-range pixels: fb_we=1, fb_color=latched color.
REQ-024: CLEAR sequence:
- Writes every pixel row-major, from (0,0) to (CANVAS_W-1, CANVAS_H-1).
- One pixel per cycle, fb_color=000, fb_we=1; CANVAS_W*CANVAS_H cycles total.
REQ-025: After the last PAINT or CLEAR write, the FSM SHALL return to IDLE at the next edge.
- At least one IDLE cycle separates consecutive operations.
- clear_done pulses in that IDLE cycle after CLEAR.
REQ-026: clear_req during CLEAR SHALL be ignored.
- clear_req during PAINT SHALL be held pending and served before any further paint.
REQ-027: paint_req while busy SHALL NOT be acknowledged; latched values SHALL NOT change mid-operation.
REQ-028: Input changes on paint_x, paint_y or color after acceptance SHALL NOT affect the ongoing paint.

Reset
REQ-029: rst_n=0 SHALL immediately force:
- state IDLE;
- paint_ack, clear_done, busy, fb_we = 0;
- fb_x, fb_y, fb_color = 0;
- the clear pending flag cleared.
REQ-030: Reset asserted mid-PAINT or mid-CLEAR SHALL abort the operation with no further writes.
- After release, the FSM waits in IDLE for a new request.

Verification
REQ-031: Paint at (10,20), color=001 -> paint_ack one cycle; 9 writes, color 001, order (9,19),(10,19),(11,19),(9,20)...(11,21); busy 9 cycles.
REQ-032: Paint at (0,0), color=111 -> 9 PAINT cycles; fb_we high only for (0,0),(1,0),(0,1),(1,1); no out-of-range address driven with fb_we=1.
REQ-033: Paint at (159,119) -> only (158,118),(159,118),(158,119),(159,119) written.
REQ-034: clear_req pulse from IDLE -> 19200 consecutive writes of 000; first (0,0), last (159,119); clear_done one cycle later.
REQ-035: Simultaneous clear_req and paint_req -> full clear first; paint_ack only after the clear_done/IDLE cycle.
- Variant: clear_req mid-paint -> paint completes, then clear runs.
REQ-036: rst_n low for 1 cycle at clear write 5000 -> fb_we=0 immediately; all outputs 0; IDLE after release; no write at pixel 5001.

Source files
------------

// File: rtl/canvas_write_scheduler.sv
// Canvas write scheduler: sole master of the frame-buffer write port.
// Stamps a square brush around a point, or clears the whole canvas, one pixel per cycle.
module canvas_write_scheduler #(
   parameter int CANVAS_W = 160,
   parameter int CANVAS_H = 120,
   parameter int BRUSH    = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       paint_req,
   input  logic [7:0] paint_x,
   input  logic [6:0] paint_y,
   input  logic [2:0] color,
   input  logic       clear_req,
   output logic       paint_ack,
   output logic       clear_done,
   output logic       busy,
   output logic       fb_we,
   output logic [7:0] fb_x,
   output logic [6:0] fb_y,
   output logic [2:0] fb_color
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PAINT = 2'd1,
      CLEAR = 2'd2
   } state_t;

   localparam logic signed [10:0] RAD    = 11'(BRUSH / 2);
   localparam logic signed [10:0] W_S    = 11'(CANVAS_W);
   localparam logic signed [10:0] H_S    = 11'(CANVAS_H);
   localparam logic [7:0]         LAST_X = 8'(CANVAS_W - 1);
   localparam logic [6:0]         LAST_Y = 7'(CANVAS_H - 1);

   state_t             state_r;
   logic               clear_pend_r;
   logic [7:0]         px_r;
   logic [6:0]         py_r;
   logic [2:0]         pcol_r;
   logic signed [10:0] dx_r;
   logic signed [10:0] dy_r;
   logic [7:0]         cx_r;
   logic [6:0]         cy_r;

   logic signed [10:0] dx_nxt_s;
   logic signed [10:0] dy_nxt_s;
   logic signed [10:0] start_x_s;
   logic signed [10:0] start_y_s;
   logic signed [10:0] next_x_s;
   logic signed [10:0] next_y_s;
   logic               start_in_s;
   logic               next_in_s;
   logic               paint_last_s;
   logic               clear_last_s;
   logic [7:0]         cx_nxt_s;
   logic [6:0]         cy_nxt_s;
   logic               clear_start_s;

   // Signed coordinates let pixels left of / above the canvas be detected and clipped.
   function automatic logic on_canvas(input logic signed [10:0] x, input logic signed [10:0] y);
      return (x >= 11'sd0) && (x < W_S) && (y >= 11'sd0) && (y < H_S);
   endfunction

   // Next brush offset, next clear pixel and the candidate pixels for the next cycle.
   always_comb begin
      paint_last_s = (dx_r == RAD) && (dy_r == RAD);
      if (dx_r == RAD) begin
         dx_nxt_s = -RAD;
         dy_nxt_s = dy_r + 11'sd1;
      end else begin
         dx_nxt_s = dx_r + 11'sd1;
         dy_nxt_s = dy_r;
      end

      clear_last_s = (cx_r == LAST_X) && (cy_r == LAST_Y);
      if (cx_r == LAST_X) begin
         cx_nxt_s = 8'd0;
         cy_nxt_s = cy_r + 7'd1;
      end else begin
         cx_nxt_s = cx_r + 8'd1;
         cy_nxt_s = cy_r;
      end

      start_x_s     = $signed({3'b000, paint_x}) - RAD;
      start_y_s     = $signed({4'b0000, paint_y}) - RAD;
      next_x_s      = $signed({3'b000, px_r}) + dx_nxt_s;
      next_y_s      = $signed({4'b0000, py_r}) + dy_nxt_s;
      start_in_s    = on_canvas(start_x_s, start_y_s);
      next_in_s     = on_canvas(next_x_s, next_y_s);
      clear_start_s = clear_pend_r || clear_req;
   end

   // Control FSM; every output is computed one edge ahead and held in a register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         clear_pend_r <= 1'b0;
         px_r         <= 8'd0;
         py_r         <= 7'd0;
         pcol_r       <= 3'b000;
         dx_r         <= 11'sd0;
         dy_r         <= 11'sd0;
         cx_r         <= 8'd0;
         cy_r         <= 7'd0;
         paint_ack    <= 1'b0;
         clear_done   <= 1'b0;
         busy         <= 1'b0;
         fb_we        <= 1'b0;
         fb_x         <= 8'd0;
         fb_y         <= 7'd0;
         fb_color     <= 3'b000;
      end else begin
         paint_ack  <= 1'b0;
         clear_done <= 1'b0;
         case (state_r)
            IDLE: begin
               if (clear_start_s) begin
                  state_r      <= CLEAR;
                  clear_pend_r <= 1'b0;
                  busy         <= 1'b1;
                  cx_r         <= 8'd0;
                  cy_r         <= 7'd0;
                  fb_we        <= 1'b1;
                  fb_x         <= 8'd0;
                  fb_y         <= 7'd0;
                  fb_color     <= 3'b000;
               end else if (paint_req) begin
                  state_r   <= PAINT;
                  busy      <= 1'b1;
                  paint_ack <= 1'b1;
                  px_r      <= paint_x;
                  py_r      <= paint_y;
                  pcol_r    <= color;
                  dx_r      <= -RAD;
                  dy_r      <= -RAD;
                  fb_we     <= start_in_s;
                  fb_x      <= start_in_s ? start_x_s[7:0] : 8'd0;
                  fb_y      <= start_in_s ? start_y_s[6:0] : 7'd0;
                  fb_color  <= color;
               end else begin
                  busy  <= 1'b0;
                  fb_we <= 1'b0;
               end
            end
            PAINT: begin
               if (clear_req) begin
                  clear_pend_r <= 1'b1;
               end
               if (paint_last_s) begin
                  state_r <= IDLE;
                  busy    <= 1'b0;
                  fb_we   <= 1'b0;
               end else begin
                  dx_r     <= dx_nxt_s;
                  dy_r     <= dy_nxt_s;
                  fb_we    <= next_in_s;
                  fb_x     <= next_in_s ? next_x_s[7:0] : 8'd0;
                  fb_y     <= next_in_s ? next_y_s[6:0] : 7'd0;
                  fb_color <= pcol_r;
               end
            end
            CLEAR: begin
               if (clear_last_s) begin
                  state_r    <= IDLE;
                  busy       <= 1'b0;
                  fb_we      <= 1'b0;
                  clear_done <= 1'b1;
               end else begin
                  cx_r     <= cx_nxt_s;
                  cy_r     <= cy_nxt_s;
                  fb_we    <= 1'b1;
                  fb_x     <= cx_nxt_s;
                  fb_y     <= cy_nxt_s;
                  fb_color <= 3'b000;
               end
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
               fb_we   <= 1'b0;
            end
         endcase
      end
   end

endmodule
